car_motion_ctrl: RTL and testbench

// Motion/dispatch stage directly upstream of the door controller in the 7-floor, 2-way elevator.
// - Consumes latched hall requests (up/down), car requests and doorState.
// - Produces currentFloor, currentDirection and moving for the door controller. moving drives the door block's reset.
// - Emits one-cycle clear pulses so the request latches drop the requests it has served.

---
 rtl/car_motion_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_car_motion_ctrl.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/car_motion_ctrl.sv
// Motion/dispatch FSM for the 7-floor elevator car. It chooses the travel direction, times
// floor-to-floor travel, and pulses latch clears for the requests served at each stop.
module car_motion_ctrl #(
  parameter int unsigned CLK_PER_FLOOR = 300000000,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:1] upRequest,
  input  logic [7:1] downRequest,
  input  logic [7:1] carRequest,
  input  logic       doorState,
  output logic [2:0] currentFloor,
  output logic [1:0] currentDirection,
  output logic       moving,
  output logic [7:1] clearUp,
  output logic [7:1] clearDown,
  output logic [7:1] clearCar
);

  localparam int CW = $clog2(CLK_PER_FLOOR);
  localparam int SW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLK_PER_FLOOR - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES);
  localparam logic [1:0] DIR_STOP = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b10;
  localparam logic [1:0] DIR_DOWN = 2'b01;

  typedef enum logic [1:0] {IDLE, MOVE, DWELL} stateType;

  stateType      state, stateNext;
  logic [CW-1:0] travelCount, travelCountNext;
  logic [SW-1:0] settleCount, settleCountNext;
  logic [2:0]    floorNext;
  logic [1:0]    dirNext;
  logic          movingNext;
  logic [7:1]    clearUpNext, clearDownNext, clearCarNext;

  logic [7:1] upValid, downValid, anyReq, hereMask, stepMask, dwellMask;
  logic [2:0] stepFloor;
  logic       goingUp, reqAbove, reqBelow, stepAbove, stepBelow;
  logic       enterDwell;
  logic [1:0] dwellDir;

  function automatic logic [7:1] floorMask(input logic [2:0] f);
    logic [7:1] m;
    for (int g = 1; g <= 7; g++) m[g] = (g == int'(f));
    return m;
  endfunction

  function automatic logic [7:1] aboveMask(input logic [2:0] f);
    logic [7:1] m;
    for (int g = 1; g <= 7; g++) m[g] = (g > int'(f));
    return m;
  endfunction

  function automatic logic [7:1] belowMask(input logic [2:0] f);
    logic [7:1] m;
    for (int g = 1; g <= 7; g++) m[g] = (g < int'(f));
    return m;
  endfunction

  function automatic logic [1:0] flipDir(input logic [1:0] d);
    return (d == DIR_UP) ? DIR_DOWN : DIR_UP;
  endfunction

  // No hall-up button exists at the top floor and no hall-down button at the bottom floor.
  assign upValid   = upRequest & 7'b0111111;
  assign downValid = downRequest & 7'b1111110;
  assign anyReq    = upValid | downValid | carRequest;
  assign goingUp   = (currentDirection == DIR_UP);
  assign stepFloor = goingUp ? currentFloor + 3'd1 : currentFloor - 3'd1;
  assign hereMask  = floorMask(currentFloor);
  assign stepMask  = floorMask(stepFloor);
  assign reqAbove  = |(anyReq & aboveMask(currentFloor));
  assign reqBelow  = |(anyReq & belowMask(currentFloor));
  assign stepAbove = |(anyReq & aboveMask(stepFloor));
  assign stepBelow = |(anyReq & belowMask(stepFloor));

  // Next-state logic; every path into DWELL funnels through enterDwell so the clear pulse is uniform.
  always_comb begin
    stateNext       = state;
    floorNext       = currentFloor;
    dirNext         = currentDirection;
    movingNext      = moving;
    travelCountNext = travelCount;
    settleCountNext = settleCount;
    enterDwell      = 1'b0;
    dwellDir        = currentDirection;
    dwellMask       = hereMask;
    case (state)
      IDLE: begin
        if (!doorState) begin
          if (|(anyReq & hereMask)) begin
            enterDwell = 1'b1;
            dwellDir   = (|((upValid | carRequest) & hereMask)) ? DIR_UP : DIR_DOWN;
          end else if (reqAbove || reqBelow) begin
            dirNext         = reqAbove ? DIR_UP : DIR_DOWN;
            movingNext      = 1'b1;
            travelCountNext = RELOAD;
            stateNext       = MOVE;
          end
        end
      end
      MOVE: begin
        if (travelCount != '0) begin
          travelCountNext = travelCount - CW'(1);
        end else begin
          floorNext = stepFloor;
          dwellMask = stepMask;
          if ((goingUp && stepFloor == 3'd7) || (!goingUp && stepFloor == 3'd1)) begin
            enterDwell = 1'b1;
            dwellDir   = flipDir(currentDirection);
          end else if (|((carRequest | (goingUp ? upValid : downValid)) & stepMask)) begin
            enterDwell = 1'b1;
          end else if (|((goingUp ? downValid : upValid) & stepMask) &&
                       !(goingUp ? stepAbove : stepBelow)) begin
            enterDwell = 1'b1;
            dwellDir   = flipDir(currentDirection);
          end else begin
            travelCountNext = RELOAD;
          end
        end
      end
      DWELL: begin
        if (settleCount != SETTLE_LAST) begin
          settleCountNext = settleCount + SW'(1);
        end else if (!doorState) begin
          if (goingUp ? reqAbove : reqBelow) begin
            movingNext      = 1'b1;
            travelCountNext = RELOAD;
            stateNext       = MOVE;
          end else if (goingUp ? reqBelow : reqAbove) begin
            dirNext         = flipDir(currentDirection);
            movingNext      = 1'b1;
            travelCountNext = RELOAD;
            stateNext       = MOVE;
          end else if (|((goingUp ? downValid : upValid) & hereMask)) begin
            enterDwell = 1'b1;
            dwellDir   = flipDir(currentDirection);
          end else begin
            dirNext   = DIR_STOP;
            stateNext = IDLE;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
    if (enterDwell) begin
      stateNext       = DWELL;
      dirNext         = dwellDir;
      movingNext      = 1'b0;
      settleCountNext = '0;
    end
    clearCarNext  = enterDwell ? dwellMask : '0;
    clearUpNext   = (enterDwell && dwellDir == DIR_UP) ? dwellMask : '0;
    clearDownNext = (enterDwell && dwellDir == DIR_DOWN) ? dwellMask : '0;
  end

  // All outputs are registered; reset parks the car at floor 1 regardless of where it was.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      currentFloor     <= 3'd1;
      currentDirection <= DIR_STOP;
      moving           <= 1'b0;
      travelCount      <= '0;
      settleCount      <= '0;
      clearUp          <= '0;
      clearDown        <= '0;
      clearCar         <= '0;
    end else begin
      state            <= stateNext;
      currentFloor     <= floorNext;
      currentDirection <= dirNext;
      moving           <= movingNext;
      travelCount      <= travelCountNext;
      settleCount      <= settleCountNext;
      clearUp          <= clearUpNext;
      clearDown        <= clearDownNext;
      clearCar         <= clearCarNext;
    end
  end

endmodule

// File: tb/tb_car_motion_ctrl.sv
// Self-checking bench for car_motion_ctrl: directed scenarios plus randomized request sets
// compared against a stop-sequence model of the collective dispatch rules.
module tb_car_motion_ctrl;
  localparam int CPF    = 4;
  localparam int SETTLE = 2;
  localparam logic [1:0] D_STOP = 2'b00;
  localparam logic [1:0] D_UP   = 2'b10;
  localparam logic [1:0] D_DOWN = 2'b01;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:1] upRequest, downRequest, carRequest;
  logic       doorState;
  logic [2:0] currentFloor;
  logic [1:0] currentDirection;
  logic       moving;
  logic [7:1] clearUp, clearDown, clearCar;

  logic [7:1] upL, dnL, carL;
  int checks = 0;
  int errors = 0;
  int modelFloor = 1;

  car_motion_ctrl #(.CLK_PER_FLOOR(CPF), .SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .reset(reset), .upRequest(upRequest), .downRequest(downRequest),
    .carRequest(carRequest), .doorState(doorState), .currentFloor(currentFloor),
    .currentDirection(currentDirection), .moving(moving), .clearUp(clearUp),
    .clearDown(clearDown), .clearCar(clearCar)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:1] bitAt(input int f);
    logic [7:1] m;
    m = '0;
    m[f] = 1'b1;
    return m;
  endfunction

  function automatic logic [1:0] dirCode(input int d);
    return (d > 0) ? D_UP : ((d < 0) ? D_DOWN : D_STOP);
  endfunction

  // Hall call in travel direction d at floor n (no up call at 7, no down call at 1).
  function automatic bit hall(input int n, input int d);
    return (d > 0) ? (n != 7 && upL[n]) : (n != 1 && dnL[n]);
  endfunction

  function automatic bit hasReq(input int n);
    return carL[n] || hall(n, 1) || hall(n, -1);
  endfunction

  function automatic bit anyBeyond(input int f, input int d);
    for (int g = f + d; g >= 1 && g <= 7; g += d)
      if (hasReq(g)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic predictStop(input int f, input int d, output int sf, output int sd);
    sf = f;
    sd = d;
    for (int n = f + d; n >= 1 && n <= 7; n += d) begin
      if ((d > 0 && n == 7) || (d < 0 && n == 1)) begin sf = n; sd = -d; return; end
      if (carL[n] || hall(n, d)) begin sf = n; sd = d; return; end
      if (hall(n, -d) && !anyBeyond(n, d)) begin sf = n; sd = -d; return; end
    end
  endtask

  task automatic drive();
    upRequest   = upL;
    downRequest = dnL;
    carRequest  = carL;
  endtask

  // One clock: sample at the falling edge, let the request latches honour any clear pulse.
  task automatic step();
    @(negedge clk);
    upL  = upL & ~clearUp;
    dnL  = dnL & ~clearDown;
    carL = carL & ~clearCar;
    drive();
  endtask

  task automatic waitPulse(input int budget, output bit ok, output int movCyc,
                           output int minF, output int maxF);
    int n = 0;
    ok = 1'b0;
    movCyc = 0;
    minF = int'(currentFloor);
    maxF = int'(currentFloor);
    while (!ok && n < budget) begin
      step();
      n++;
      if (moving) movCyc++;
      if (int'(currentFloor) < minF) minF = int'(currentFloor);
      if (int'(currentFloor) > maxF) maxF = int'(currentFloor);
      if (clearCar != '0) ok = 1'b1;
    end
  endtask

  task automatic waitIdle(input int budget, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (!ok && n < budget) begin
      step();
      n++;
      if (currentDirection == D_STOP && !moving) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    doorState = 1'b0;
    upL = '0; dnL = '0; carL = '0;
    drive();
    #12;
    checks++;
    if ({currentFloor, currentDirection, moving} !== {3'd1, D_STOP, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_state got %b want %b", {currentFloor, currentDirection, moving}, {3'd1, D_STOP, 1'b0});
    end
    checks++;
    if ({clearUp, clearDown, clearCar} !== 21'd0) begin
      errors++;
      $display("[TB] FAIL reset_clears got %h want 0", {clearUp, clearDown, clearCar});
    end
    @(negedge clk);
    reset = 1'b0;
    step();
    step();
    checks++;
    if ({currentFloor, moving} !== {3'd1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL idle_after_reset got floor %0d moving %b want 1 0", currentFloor, moving);
    end
  endtask

  task automatic test_single_car();
    int bad = 0;
    bit ok;
    carL[4] = 1'b1;
    drive();
    step();
    checks++;
    if (moving !== 1'b1 || currentDirection !== D_UP) begin
      errors++;
      $display("[TB] FAIL depart got moving %b dir %b want 1 10", moving, currentDirection);
    end
    for (int t = 1; t <= 3 * CPF; t++) begin
      step();
      if (currentFloor !== 3'(1 + t / CPF)) bad++;
      if (t < 3 * CPF && moving !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL travel_profile got %0d bad samples want 0", bad);
    end
    checks++;
    if (moving !== 1'b0 || clearCar !== bitAt(4)) begin
      errors++;
      $display("[TB] FAIL arrive_4 got moving %b clearCar %b want 0 %b", moving, clearCar, bitAt(4));
    end
    step();
    checks++;
    if (clearCar !== 7'b0) begin
      errors++;
      $display("[TB] FAIL pulse_width got clearCar %b want 0", clearCar);
    end
    waitIdle(20, ok);
    checks++;
    if (!ok || currentFloor !== 3'd4) begin
      errors++;
      $display("[TB] FAIL idle_at_4 got ok %b floor %0d want 1 4", ok, currentFloor);
    end
  endtask

  task automatic test_up_run();
    bit ok;
    int mc, mn, mx;
    carL[1] = 1'b1;
    drive();
    waitPulse(100, ok, mc, mn, mx);
    waitIdle(20, ok);
    upL[3] = 1'b1; dnL[3] = 1'b1; carL[5] = 1'b1;
    drive();
    waitPulse(100, ok, mc, mn, mx);
    checks++;
    if (!ok || currentFloor !== 3'd3 || currentDirection !== D_UP || clearUp !== bitAt(3) ||
        clearDown !== 7'b0 || mc != 2 * CPF) begin
      errors++;
      $display("[TB] FAIL stop_up3 got ok %b fl %0d dir %b cu %b cd %b mc %0d want 1 3 10 %b 0 %0d",
               ok, currentFloor, currentDirection, clearUp, clearDown, mc, bitAt(3), 2 * CPF);
    end
    waitPulse(100, ok, mc, mn, mx);
    checks++;
    if (!ok || currentFloor !== 3'd5 || clearCar !== bitAt(5) || mc != 2 * CPF) begin
      errors++;
      $display("[TB] FAIL stop_car5 got ok %b fl %0d cc %b mc %0d want 1 5 %b %0d",
               ok, currentFloor, clearCar, mc, bitAt(5), 2 * CPF);
    end
    waitPulse(100, ok, mc, mn, mx);
    checks++;
    if (!ok || currentFloor !== 3'd3 || currentDirection !== D_DOWN || clearDown !== bitAt(3) ||
        clearUp !== 7'b0 || mc != 2 * CPF) begin
      errors++;
      $display("[TB] FAIL stop_down3 got ok %b fl %0d dir %b cd %b cu %b mc %0d want 1 3 01 %b 0 %0d",
               ok, currentFloor, currentDirection, clearDown, clearUp, mc, bitAt(3), 2 * CPF);
    end
    waitIdle(20, ok);
    checks++;
    if (!ok || currentFloor !== 3'd3) begin
      errors++;
      $display("[TB] FAIL idle_at_3 got ok %b floor %0d want 1 3", ok, currentFloor);
    end
  endtask

  task automatic test_top_limit();
    bit ok;
    int mc, mn, mx;
    carL[6] = 1'b1;
    drive();
    waitPulse(100, ok, mc, mn, mx);
    waitIdle(20, ok);
    dnL[7] = 1'b1;
    drive();
    waitPulse(100, ok, mc, mn, mx);
    checks++;
    if (!ok || currentFloor !== 3'd7 || currentDirection !== D_DOWN || clearDown !== bitAt(7) ||
        clearUp !== 7'b0) begin
      errors++;
      $display("[TB] FAIL top_stop got ok %b fl %0d dir %b cd %b cu %b want 1 7 01 %b 0",
               ok, currentFloor, currentDirection, clearDown, clearUp, bitAt(7));
    end
    checks++;
    if (mn != 6 || mx != 7 || mc != CPF) begin
      errors++;
      $display("[TB] FAIL top_range got min %0d max %0d mc %0d want 6 7 %0d", mn, mx, mc, CPF);
    end
    waitIdle(20, ok);
    checks++;
    if (!ok || currentFloor !== 3'd7) begin
      errors++;
      $display("[TB] FAIL idle_at_7 got ok %b floor %0d want 1 7", ok, currentFloor);
    end
  endtask

  task automatic test_door_hold();
    bit ok;
    int mc, mn, mx;
    int bad = 0;
    carL[5] = 1'b1; carL[3] = 1'b1;
    drive();
    waitPulse(100, ok, mc, mn, mx);
    checks++;
    if (!ok || currentFloor !== 3'd5 || currentDirection !== D_DOWN) begin
      errors++;
      $display("[TB] FAIL hold_arrive got ok %b fl %0d dir %b want 1 5 01", ok, currentFloor, currentDirection);
    end
    doorState = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      if (currentFloor !== 3'd5 || moving !== 1'b0 || clearCar !== 7'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL door_hold got %0d bad samples want 0", bad);
    end
    doorState = 1'b0;
    step();
    checks++;
    if (moving !== 1'b1 || currentDirection !== D_DOWN || currentFloor !== 3'd5) begin
      errors++;
      $display("[TB] FAIL resume got moving %b dir %b fl %0d want 1 01 5", moving, currentDirection, currentFloor);
    end
    waitPulse(100, ok, mc, mn, mx);
    checks++;
    if (!ok || currentFloor !== 3'd3) begin
      errors++;
      $display("[TB] FAIL hold_next got ok %b floor %0d want 1 3", ok, currentFloor);
    end
    waitIdle(20, ok);
  endtask

  task automatic test_same_floor();
    bit ok;
    int mc, mn, mx;
    carL[3] = 1'b1; upL[5] = 1'b1;
    drive();
    waitPulse(3, ok, mc, mn, mx);
    checks++;
    if (!ok || mc != 0 || currentFloor !== 3'd3 || currentDirection !== D_UP ||
        clearCar !== bitAt(3) || clearUp !== bitAt(3)) begin
      errors++;
      $display("[TB] FAIL here_first got ok %b mc %0d fl %0d dir %b cc %b cu %b want 1 0 3 10 %b %b",
               ok, mc, currentFloor, currentDirection, clearCar, clearUp, bitAt(3), bitAt(3));
    end
    waitPulse(100, ok, mc, mn, mx);
    checks++;
    if (!ok || currentFloor !== 3'd5 || clearUp !== bitAt(5) || mc != 2 * CPF) begin
      errors++;
      $display("[TB] FAIL then_5 got ok %b fl %0d cu %b mc %0d want 1 5 %b %0d",
               ok, currentFloor, clearUp, mc, bitAt(5), 2 * CPF);
    end
    waitIdle(20, ok);
  endtask

  task automatic test_reset_mid_move();
    carL[1] = 1'b1;
    drive();
    repeat (6) step();
    checks++;
    if (moving !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pre_reset_moving got %b want 1", moving);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({currentFloor, currentDirection, moving, clearUp, clearDown, clearCar} !==
        {3'd1, D_STOP, 1'b0, 21'd0}) begin
      errors++;
      $display("[TB] FAIL reset_mid_move got fl %0d dir %b mv %b clr %h want 1 00 0 0",
               currentFloor, currentDirection, moving, {clearUp, clearDown, clearCar});
    end
    upL = '0; dnL = '0; carL = '0;
    drive();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) step();
    checks++;
    if ({currentFloor, currentDirection, moving} !== {3'd1, D_STOP, 1'b0}) begin
      errors++;
      $display("[TB] FAIL post_reset_idle got fl %0d dir %b mv %b want 1 00 0",
               currentFloor, currentDirection, moving);
    end
    modelFloor = 1;
  endtask

  task automatic test_random();
    bit ok, done, abort;
    int mc, mn, mx, md, expF, expD, expMc, k, bad;
    abort = 1'b0;
    for (int r = 0; r < 25 && !abort; r++) begin
      upL = '0; dnL = '0; carL = '0;
      for (int g = 1; g <= 7; g++) begin
        if ($urandom_range(0, 4) == 0) upL[g] = 1'b1;
        if ($urandom_range(0, 4) == 0) dnL[g] = 1'b1;
        if ($urandom_range(0, 5) == 0) carL[g] = 1'b1;
      end
      if (!(hasReq(1) || anyBeyond(1, 1))) carL[$urandom_range(1, 7)] = 1'b1;
      drive();
      if (hasReq(modelFloor)) begin
        expF = modelFloor;
        expD = (hall(modelFloor, 1) || carL[modelFloor]) ? 1 : -1;
      end else begin
        predictStop(modelFloor, anyBeyond(modelFloor, 1) ? 1 : -1, expF, expD);
      end
      expMc = CPF * ((expF > modelFloor) ? expF - modelFloor : modelFloor - expF);
      done = 1'b0;
      while (!done && !abort) begin
        waitPulse(40 * CPF, ok, mc, mn, mx);
        checks++;
        if (!ok || currentFloor !== 3'(expF) || currentDirection !== dirCode(expD) || mc != expMc) begin
          errors++;
          $display("[TB] FAIL rand_stop r%0d got ok %b fl %0d dir %b mc %0d want 1 %0d %b %0d",
                   r, ok, currentFloor, currentDirection, mc, expF, dirCode(expD), expMc);
          abort = !ok;
        end
        checks++;
        if (clearCar !== bitAt(expF) || clearUp !== (expD > 0 ? bitAt(expF) : 7'b0) ||
            clearDown !== (expD < 0 ? bitAt(expF) : 7'b0)) begin
          errors++;
          $display("[TB] FAIL rand_clears r%0d got %b %b %b want car at %0d dir %0d",
                   r, clearUp, clearDown, clearCar, expF, expD);
        end
        modelFloor = expF;
        md = expD;
        k = $urandom_range(0, 8);
        bad = 0;
        if (k > 0) begin
          doorState = 1'b1;
          repeat (k) begin
            step();
            if (moving !== 1'b0 || currentFloor !== 3'(modelFloor)) bad++;
          end
          doorState = 1'b0;
          checks++;
          if (bad != 0) begin
            errors++;
            $display("[TB] FAIL rand_door r%0d got %0d bad samples want 0", r, bad);
          end
        end
        if (anyBeyond(modelFloor, md)) begin
          predictStop(modelFloor, md, expF, expD);
        end else if (anyBeyond(modelFloor, -md)) begin
          predictStop(modelFloor, -md, expF, expD);
        end else if (hall(modelFloor, -md)) begin
          expF = modelFloor;
          expD = -md;
        end else begin
          done = 1'b1;
        end
        expMc = CPF * ((expF > modelFloor) ? expF - modelFloor : modelFloor - expF);
      end
      if (!abort) begin
        waitIdle(40, ok);
        checks++;
        if (!ok || currentFloor !== 3'(modelFloor)) begin
          errors++;
          $display("[TB] FAIL rand_idle r%0d got ok %b fl %0d want 1 %0d", r, ok, currentFloor, modelFloor);
          abort = 1'b1;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_car();
    test_up_run();
    test_top_limit();
    test_door_hold();
    test_same_floor();
    test_reset_mid_move();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
